mips32_pipe: RTL and testbench
==============================

// Module: mips32_pipe
// PURPOSE
//  Five-stage pipelined MIPS32-subset processor core: IF, ID, EX, MEM, WB.
//  - Self-contained: unified word-addressed instruction/data memory and a 32x32 register file.
//  - Program and data are preloaded hierarchically; the only ports are clock and reset.
//  - Runs until HLT retires.
// PARAMETERS
//  MEM_DEPTH  1024  words in Memory; PC and data addresses index words, wrap modulo MEM_DEPTH
// PORTS
//  clk    input  1  single clock, all state updates on posedge
//  rst_n  input  1  reset, asynchronous, active-low
// BEHAVIOUR
//  State visible to the bench (hierarchical names):
//  - Memory[0:MEM_DEPTH-1][31:0]
//  - RegFile[0:31][31:0]
//  - PC[31:0]
//  - HALTED
//  - TAKEN_BRANCH
//  Reset (rst_n=0):
//  - PC=0, HALTED=0, TAKEN_BRANCH=0.
//  - All pipeline latches hold bubbles (no reg/mem write).
//  - Memory and RegFile are not reset.
//  Encoding:
//  - Fields: op[31:26] rs[25:21] rt[20:16].
//  - R-type: rd[15:11]. I-type: imm[15:0], sign-extended.
//  - R-type ops, rd=rs op rt: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101.
//  - Immediate ops, rt=rs op imm: ADDI 001010, SUBI 001011, SLTI 001100.
//  - LW 001000: rt=Mem[rs+imm]. SW 001001: Mem[rs+imm]=rt.
//  - BNEQZ 001101 / BEQZ 001110: test rs; target=branchPC+1+imm.
//  - HLT 111111. Any other opcode is a bubble.
//  Arithmetic:
//  - 32-bit wrap. MUL keeps the low 32 bits. SLT/SLTI are signed, result 1/0.
//  - RegFile[0] always reads 0; writes to R0 are discarded.
//  Timing: an instruction in IF at edge k is in ID at k+1, EX at k+2, MEM at k+3, and writes RegFile at k+4.
//  - Memory reads (IF and MEM) are combinational; the SW write lands on the MEM edge.
//  Hazards:
//  - EX forwards from EX/MEM (ALU result) and MEM/WB (ALU or load data), youngest first.
//  - The register file is write-before-read: ID sees the value WB writes in the same cycle.
//  - There is no load-use interlock. A consumer directly after LW needs >=1 instruction gap (software).
//  Branches:
//  - Resolved in EX. If taken, PC <= target on that edge, and the IF/ID and ID/EX contents are flushed (2 bubbles).
//  - TAKEN_BRANCH=1 for exactly that cycle. There are no delay slots.
//  HLT:
//  - When decoded in ID, fetch stops: PC frozen, bubbles enter.
//  - Older instructions drain normally.
//  - HALTED<=1 when HLT reaches WB; thereafter no PC, RegFile or Memory change until reset.
//  - Reset mid-run returns to the reset state immediately and restarts from PC=0 on release.
// TESTING
//  - Straight-line: ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; ADD R4,R2,R1; ADD R5,R4,R3; HLT
//    -> R4=30, R5=55 (back-to-back dependences, no dummies).
//  - Factorial: 280a00c8, 28020001, 0ce77800, 21430000, 0ce77800, 14431000, 2c630001, 0ce77800, 3460fffc, 2542fffe, fc000000,
//    with Mem[200]=6 -> Mem[198]=720, R3=0, HALTED=1.
//  - Fibonacci: 280900c8, 00000800, 28020001, 212a0000, 0ce77800, 0ce77800, 2d4a0002, 00221800, 00400800, 00601000, 2d4a0001,
//    0ce77800, 0ce77800, 3540fff9, 2523fffe, fc000000, with Mem[200]=10 -> Mem[198]=34, R10=0.
//  - Branch flush: taken BNEQZ followed by two ADDIs to R8 -> R8 unchanged; TAKEN_BRANCH high for 1 cycle.
//  - Halt: HLT followed by SW and ADDI -> neither commits, PC frozen, HALTED=1 and stays.
//  - Reset: assert rst_n=0 mid-loop -> PC=0, HALTED=0 immediately; after release the program reruns to the same results.

Source files
------------

// File: rtl/mips32_pipe.sv
// Five-stage MIPS32-subset core (IF, ID, EX, MEM, WB) with a unified word memory, EX-stage
// forwarding, a write-before-read register file and branches resolved in EX.
module mips32_pipe #(
    parameter int MEM_DEPTH = 1024
) (
    input logic clk,
    input logic rst_n
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {K_NONE, K_ALU, K_LW, K_SW, K_BR, K_HLT} kind_t;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_MUL} alu_t;

    logic [31:0] Memory [0:MEM_DEPTH-1];
    logic [31:0] RegFile [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        fetch_stop;

    logic        if_id_valid;
    logic [31:0] if_id_ir, if_id_npc;

    kind_t       id_ex_kind;
    alu_t        id_ex_alu;
    logic        id_ex_use_imm, id_ex_bnez;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

    kind_t       ex_mem_kind;
    logic [4:0]  ex_mem_dst;
    logic [31:0] ex_mem_alu, ex_mem_b;

    kind_t       mem_wb_kind;
    logic [4:0]  mem_wb_dst;
    logic [31:0] mem_wb_data;

    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_dst;
    kind_t       id_kind;
    alu_t        id_alu;
    logic        id_use_imm, id_hlt;
    logic [31:0] id_imm, id_a, id_b;

    logic [31:0] ex_a, ex_b, ex_opb, ex_res, ex_target;
    logic        ex_taken;
    logic [31:0] mem_rdata;
    logic        wb_we, mem_we;

    assign wb_we  = (mem_wb_kind == K_ALU || mem_wb_kind == K_LW) && mem_wb_dst != 5'd0 && !HALTED;
    assign mem_we = (ex_mem_kind == K_SW) && !HALTED;
    assign id_hlt = if_id_valid && id_op == 6'b111111;

    // Decode; non-writing instructions carry dst=0 so forwarding never matches them.
    always_comb begin
        id_op      = if_id_ir[31:26];
        id_rs      = if_id_ir[25:21];
        id_rt      = if_id_ir[20:16];
        id_imm     = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
        id_kind    = K_NONE;
        id_alu     = A_ADD;
        id_use_imm = 1'b0;
        id_dst     = 5'd0;
        if (if_id_valid) begin
            case (id_op)
                6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101: begin
                    id_kind = K_ALU;
                    id_alu  = alu_t'(id_op[2:0]);
                    id_dst  = if_id_ir[15:11];
                end
                6'b001010, 6'b001011, 6'b001100: begin
                    id_kind    = K_ALU;
                    id_alu     = (id_op == 6'b001010) ? A_ADD : (id_op == 6'b001011) ? A_SUB : A_SLT;
                    id_use_imm = 1'b1;
                    id_dst     = id_rt;
                end
                6'b001000: begin id_kind = K_LW; id_use_imm = 1'b1; id_dst = id_rt; end
                6'b001001: begin id_kind = K_SW; id_use_imm = 1'b1; end
                6'b001101, 6'b001110: id_kind = K_BR;
                6'b111111: id_kind = K_HLT;
                default:   id_kind = K_NONE;
            endcase
        end
        id_a = (wb_we && mem_wb_dst == id_rs) ? mem_wb_data : RegFile[id_rs];
        id_b = (wb_we && mem_wb_dst == id_rt) ? mem_wb_data : RegFile[id_rt];
        if (id_rs == 5'd0) id_a = '0;
        if (id_rt == 5'd0) id_b = '0;
    end

    // Execute with youngest-first forwarding; a load in EX/MEM has no data yet.
    always_comb begin
        ex_a = id_ex_a;
        if (ex_mem_kind == K_ALU && ex_mem_dst != 5'd0 && ex_mem_dst == id_ex_rs) ex_a = ex_mem_alu;
        else if (wb_we && mem_wb_dst == id_ex_rs) ex_a = mem_wb_data;
        ex_b = id_ex_b;
        if (ex_mem_kind == K_ALU && ex_mem_dst != 5'd0 && ex_mem_dst == id_ex_rt) ex_b = ex_mem_alu;
        else if (wb_we && mem_wb_dst == id_ex_rt) ex_b = mem_wb_data;
        ex_opb = id_ex_use_imm ? id_ex_imm : ex_b;
        case (id_ex_alu)
            A_SUB:   ex_res = ex_a - ex_opb;
            A_AND:   ex_res = ex_a & ex_opb;
            A_OR:    ex_res = ex_a | ex_opb;
            A_SLT:   ex_res = ($signed(ex_a) < $signed(ex_opb)) ? 32'd1 : 32'd0;
            A_MUL:   ex_res = ex_a * ex_opb;
            default: ex_res = ex_a + ex_opb;
        endcase
        ex_taken  = (id_ex_kind == K_BR) && (id_ex_bnez ? (ex_a != 32'd0) : (ex_a == 32'd0));
        ex_target = id_ex_npc + id_ex_imm;
        mem_rdata = Memory[ex_mem_alu[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC <= '0;  HALTED <= 1'b0;  TAKEN_BRANCH <= 1'b0;  fetch_stop <= 1'b0;
            if_id_valid <= 1'b0;  if_id_ir <= '0;  if_id_npc <= '0;
            id_ex_kind <= K_NONE;  id_ex_alu <= A_ADD;  id_ex_use_imm <= 1'b0;  id_ex_bnez <= 1'b0;
            id_ex_rs <= '0;  id_ex_rt <= '0;  id_ex_dst <= '0;
            id_ex_a <= '0;  id_ex_b <= '0;  id_ex_imm <= '0;  id_ex_npc <= '0;
            ex_mem_kind <= K_NONE;  ex_mem_dst <= '0;  ex_mem_alu <= '0;  ex_mem_b <= '0;
            mem_wb_kind <= K_NONE;  mem_wb_dst <= '0;  mem_wb_data <= '0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= ex_taken;
            if (ex_taken) begin
                PC          <= ex_target;
                if_id_valid <= 1'b0;
            end else if (fetch_stop || id_hlt) begin
                if_id_valid <= 1'b0;
            end else begin
                if_id_valid <= 1'b1;
                if_id_ir    <= Memory[PC[AW-1:0]];
                if_id_npc   <= PC + 32'd1;
                PC          <= PC + 32'd1;
            end
            if (id_hlt && !ex_taken) fetch_stop <= 1'b1;

            id_ex_kind    <= ex_taken ? K_NONE : id_kind;
            id_ex_alu     <= id_alu;
            id_ex_use_imm <= id_use_imm;
            id_ex_bnez    <= (id_op == 6'b001101);
            id_ex_rs      <= id_rs;
            id_ex_rt      <= id_rt;
            id_ex_dst     <= ex_taken ? 5'd0 : id_dst;
            id_ex_a       <= id_a;
            id_ex_b       <= id_b;
            id_ex_imm     <= id_imm;
            id_ex_npc     <= if_id_npc;

            ex_mem_kind <= id_ex_kind;
            ex_mem_dst  <= id_ex_dst;
            ex_mem_alu  <= ex_res;
            ex_mem_b    <= ex_b;

            mem_wb_kind <= ex_mem_kind;
            mem_wb_dst  <= ex_mem_dst;
            mem_wb_data <= (ex_mem_kind == K_LW) ? mem_rdata : ex_mem_alu;
            if (mem_wb_kind == K_HLT) HALTED <= 1'b1;
        end
    end

    // Architectural storage is not reset; program and data are preloaded.
    always_ff @(posedge clk) begin
        if (mem_we) Memory[ex_mem_alu[AW-1:0]] <= ex_mem_b;
        if (wb_we) RegFile[mem_wb_dst] <= mem_wb_data;
    end
endmodule

// File: tb/tb_mips32_pipe.sv
// Bench for mips32_pipe: directed programs plus random straight-line programs checked
// against an instruction-level interpreter of the architecture.
module tb_mips32_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    mips32_pipe #(.MEM_DEPTH(1024)) dut (.clk(clk), .rst_n(rst_n));

    always #5 clk = ~clk;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
    localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_reg [0:31];
    int ref_taken;
    int dut_taken;
    int ncycles;

    function automatic logic [31:0] enc_r(logic [5:0] op, int rd, int rs, int rt);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rt, int rs, int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) ref_reg[i] = 32'd0;
    endtask

    // Architectural interpreter: one instruction at a time, no pipeline.
    task automatic ref_run();
        int pc;
        logic [31:0] ir, a, b, imm, addr;
        logic [5:0] op;
        int rs, rt, rd;
        pc = 0;
        ref_taken = 0;
        for (int s = 0; s < 20000; s++) begin
            ir = ref_mem[pc & 1023];
            op = ir[31:26]; rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a = (rs == 0) ? 32'd0 : ref_reg[rs];
            b = (rt == 0) ? 32'd0 : ref_reg[rt];
            pc = pc + 1;
            case (op)
                OP_ADD:  if (rd != 0) ref_reg[rd] = a + b;
                OP_SUB:  if (rd != 0) ref_reg[rd] = a - b;
                OP_AND:  if (rd != 0) ref_reg[rd] = a & b;
                OP_OR:   if (rd != 0) ref_reg[rd] = a | b;
                OP_SLT:  if (rd != 0) ref_reg[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                OP_MUL:  if (rd != 0) ref_reg[rd] = a * b;
                OP_ADDI: if (rt != 0) ref_reg[rt] = a + imm;
                OP_SUBI: if (rt != 0) ref_reg[rt] = a - imm;
                OP_SLTI: if (rt != 0) ref_reg[rt] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                OP_LW:   begin addr = a + imm; if (rt != 0) ref_reg[rt] = ref_mem[addr[9:0]]; end
                OP_SW:   begin addr = a + imm; ref_mem[addr[9:0]] = b; end
                OP_BNEQZ: if (a != 0) begin pc = pc + int'($signed(imm)); ref_taken++; end
                OP_BEQZ:  if (a == 0) begin pc = pc + int'($signed(imm)); ref_taken++; end
                OP_HLT:  return;
                default: ;
            endcase
        end
    endtask

    // Hold reset, copy the reference memory image into the core, release.
    task automatic start_run();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Memory[i] <= ref_mem[i];
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string name);
        bit done;
        done = 0;
        dut_taken = 0;
        ncycles = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            ncycles++;
            if (dut.TAKEN_BRANCH) dut_taken++;
            if (dut.HALTED) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s halt: HALTED=%0b after %0d cycles, required 1", name, dut.HALTED, ncycles);
        end
        $display("run %s: %0d cycles, %0d taken-branch cycles", name, ncycles, dut_taken);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp += 3;
        if (dut.PC !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %0d, expected 0", dut.PC); end
        if (dut.HALTED !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b, expected 0", dut.HALTED); end
        if (dut.TAKEN_BRANCH !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %0b, expected 0", dut.TAKEN_BRANCH); end
    endtask

    task automatic test_straight();
        logic [31:0] exp_r [1:5];
        clear_ref();
        ref_mem[0] = enc_i(OP_ADDI, 1, 0, 10);
        ref_mem[1] = enc_i(OP_ADDI, 2, 0, 20);
        ref_mem[2] = enc_i(OP_ADDI, 3, 0, 25);
        ref_mem[3] = enc_r(OP_ADD, 4, 2, 1);
        ref_mem[4] = enc_r(OP_ADD, 5, 4, 3);
        ref_mem[5] = {OP_HLT, 26'd0};
        exp_r = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
        start_run();
        run_to_halt("straight");
        for (int r = 1; r <= 5; r++) begin
            n_cmp++;
            if (dut.RegFile[r] !== exp_r[r]) begin
                n_bad++;
                $display("FAIL straight_R%0d: got %0d, expected %0d", r, dut.RegFile[r], exp_r[r]);
            end
        end
    endtask

    task automatic test_factorial();
        logic [31:0] prog [0:10];
        prog = '{32'h280a00c8, 32'h28020001, 32'h0ce77800, 32'h21430000, 32'h0ce77800, 32'h14431000,
                 32'h2c630001, 32'h0ce77800, 32'h3460fffc, 32'h2542fffe, 32'hfc000000};
        clear_ref();
        for (int i = 0; i < 11; i++) ref_mem[i] = prog[i];
        ref_mem[200] = 32'd6;
        start_run();
        ref_run();
        run_to_halt("factorial");
        n_cmp += 3;
        if (dut.Memory[198] !== 32'd720) begin n_bad++; $display("FAIL fact_mem198: got %0d, expected 720", dut.Memory[198]); end
        if (dut.RegFile[3] !== 32'd0) begin n_bad++; $display("FAIL fact_R3: got %0d, expected 0", dut.RegFile[3]); end
        if (dut_taken != ref_taken) begin n_bad++; $display("FAIL fact_taken_cycles: got %0d, expected %0d", dut_taken, ref_taken); end
    endtask

    task automatic test_fibonacci();
        logic [31:0] prog [0:15];
        prog = '{32'h280900c8, 32'h00000800, 32'h28020001, 32'h212a0000, 32'h0ce77800, 32'h0ce77800,
                 32'h2d4a0002, 32'h00221800, 32'h00400800, 32'h00601000, 32'h2d4a0001, 32'h0ce77800,
                 32'h0ce77800, 32'h3540fff9, 32'h2523fffe, 32'hfc000000};
        clear_ref();
        for (int i = 0; i < 16; i++) ref_mem[i] = prog[i];
        ref_mem[200] = 32'd10;
        start_run();
        run_to_halt("fibonacci");
        n_cmp += 2;
        if (dut.Memory[198] !== 32'd34) begin n_bad++; $display("FAIL fib_mem198: got %0d, expected 34", dut.Memory[198]); end
        if (dut.RegFile[10] !== 32'd0) begin n_bad++; $display("FAIL fib_R10: got %0d, expected 0", dut.RegFile[10]); end
    endtask

    task automatic test_branch_flush();
        clear_ref();
        ref_mem[0] = enc_i(OP_ADDI, 8, 0, 77);
        ref_mem[1] = enc_i(OP_ADDI, 1, 0, 1);
        ref_mem[2] = enc_i(OP_BNEQZ, 0, 1, 2);
        ref_mem[3] = enc_i(OP_ADDI, 8, 8, 1);
        ref_mem[4] = enc_i(OP_ADDI, 8, 8, 1);
        ref_mem[5] = {OP_HLT, 26'd0};
        start_run();
        run_to_halt("branch_flush");
        n_cmp += 2;
        if (dut.RegFile[8] !== 32'd77) begin n_bad++; $display("FAIL flush_R8: got %0d, expected 77", dut.RegFile[8]); end
        if (dut_taken != 1) begin n_bad++; $display("FAIL flush_taken_cycles: got %0d, expected 1", dut_taken); end
    endtask

    task automatic test_halt();
        clear_ref();
        ref_mem[0] = enc_i(OP_ADDI, 9, 0, 5);
        ref_mem[1] = {OP_HLT, 26'd0};
        ref_mem[2] = enc_i(OP_SW, 9, 0, 300);
        ref_mem[3] = enc_i(OP_ADDI, 9, 0, 99);
        ref_mem[300] = 32'h0000dead;
        start_run();
        run_to_halt("halt");
        n_cmp++;
        if (dut.PC !== 32'd2) begin n_bad++; $display("FAIL halt_pc: got %0d, expected 2", dut.PC); end
        repeat (20) @(negedge clk);
        n_cmp += 4;
        if (dut.PC !== 32'd2) begin n_bad++; $display("FAIL halt_pc_frozen: got %0d, expected 2", dut.PC); end
        if (dut.HALTED !== 1'b1) begin n_bad++; $display("FAIL halt_sticky: got %0b, expected 1", dut.HALTED); end
        if (dut.RegFile[9] !== 32'd5) begin n_bad++; $display("FAIL halt_R9: got %0d, expected 5", dut.RegFile[9]); end
        if (dut.Memory[300] !== 32'h0000dead) begin n_bad++; $display("FAIL halt_mem300: got %h, expected 0000dead", dut.Memory[300]); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] prog [0:10];
        prog = '{32'h280a00c8, 32'h28020001, 32'h0ce77800, 32'h21430000, 32'h0ce77800, 32'h14431000,
                 32'h2c630001, 32'h0ce77800, 32'h3460fffc, 32'h2542fffe, 32'hfc000000};
        clear_ref();
        for (int i = 0; i < 11; i++) ref_mem[i] = prog[i];
        ref_mem[200] = 32'd6;
        start_run();
        repeat (25) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (dut.PC !== 32'd0) begin n_bad++; $display("FAIL midrun_reset_pc: got %0d, expected 0", dut.PC); end
        if (dut.HALTED !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_halted: got %0b, expected 0", dut.HALTED); end
        @(negedge clk);
        dut.Memory[198] <= 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_to_halt("reset_rerun");
        n_cmp++;
        if (dut.Memory[198] !== 32'd720) begin n_bad++; $display("FAIL rerun_mem198: got %0d, expected 720", dut.Memory[198]); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (dut.HALTED !== 1'b0) begin n_bad++; $display("FAIL post_halt_reset_halted: got %0b, expected 0", dut.HALTED); end
        if (dut.PC !== 32'd0) begin n_bad++; $display("FAIL post_halt_reset_pc: got %0d, expected 0", dut.PC); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random programs; every LW is followed by a NOP, branches only jump forward.
    task automatic test_random(input int iter);
        int n, kind;
        logic [5:0] ops_r [0:5];
        logic [5:0] ops_i [0:2];
        ops_r = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
        ops_i = '{OP_ADDI, OP_SUBI, OP_SLTI};
        clear_ref();
        n = 0;
        for (int r = 1; r < 8; r++) ref_mem[n++] = enc_i(OP_ADDI, r, 0, int'($urandom_range(0, 65535)));
        for (int k = 0; k < 8; k++) ref_mem[400 + k] = $urandom;
        for (int j = 0; j < 30; j++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 4)
                ref_mem[n++] = enc_r(ops_r[$urandom_range(0, 5)], int'($urandom_range(0, 7)),
                                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else if (kind <= 6)
                ref_mem[n++] = enc_i(ops_i[$urandom_range(0, 2)], int'($urandom_range(0, 7)),
                                     int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
            else if (kind == 7)
                ref_mem[n++] = enc_i(OP_SW, int'($urandom_range(0, 7)), 0, 400 + int'($urandom_range(0, 7)));
            else if (kind == 8) begin
                ref_mem[n++] = enc_i(OP_LW, int'($urandom_range(0, 7)), 0, 400 + int'($urandom_range(0, 7)));
                ref_mem[n++] = 32'd0;
            end else
                ref_mem[n++] = enc_i(($urandom_range(0, 1) == 0) ? OP_BEQZ : OP_BNEQZ, 0,
                                     int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end
        for (int h = 0; h < 3; h++) ref_mem[n++] = {OP_HLT, 26'd0};
        start_run();
        ref_run();
        run_to_halt($sformatf("random%0d", iter));
        for (int r = 1; r < 8; r++) begin
            n_cmp++;
            if (dut.RegFile[r] !== ref_reg[r]) begin
                n_bad++;
                $display("FAIL random%0d_R%0d: got %h, expected %h", iter, r, dut.RegFile[r], ref_reg[r]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (dut.Memory[400 + k] !== ref_mem[400 + k]) begin
                n_bad++;
                $display("FAIL random%0d_mem%0d: got %h, expected %h", iter, 400 + k, dut.Memory[400 + k], ref_mem[400 + k]);
            end
        end
        n_cmp++;
        if (dut_taken != ref_taken) begin
            n_bad++;
            $display("FAIL random%0d_taken_cycles: got %0d, expected %0d", iter, dut_taken, ref_taken);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_factorial();
        test_fibonacci();
        test_branch_flush();
        test_halt();
        test_reset_midrun();
        for (int it = 0; it < 8; it++) test_random(it);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
